// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, PCNext select, IF/ID register.
// Ports: clk/reset, hazard controls (stallF, stallD, FlushD), Execute
// redirect (PcSrcE, PCTargetE), BRAM (imem_addr, imem_rdata), IF/ID
// outputs (InstrD, PCD, PCPlus4D, ValidD) and perf counters.
// Optional: define FETCH_PERF_CNT_EN to build the perf counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        FlushD,
  input  logic        PcSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {PRIME, RUN} state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        run;

  assign run      = (state == RUN);
  assign pc_plus4 = PCF + 32'd4;

  // PRIME re-presents PCF so the BRAM output lines up with PCF
  always_comb begin
    pc_next = PCF;
    if (reset)
      pc_next = RESET_PC;
    else if (run) begin
      if (PcSrcE)
        pc_next = PCTargetE & 32'hFFFF_FFFC;
      else if (!stallF)
        pc_next = pc_plus4;
    end
  end

  assign imem_addr = pc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PRIME;
      PCF      <= RESET_PC;
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else begin
      state <= RUN;
      PCF   <= pc_next;
      if (!run || FlushD) begin
        InstrD   <= NOP_INSTR;
        PCD      <= 32'd0;
        PCPlus4D <= 32'd0;
        ValidD   <= 1'b0;
      end else if (!stallD) begin
        InstrD   <= imem_rdata;
        PCD      <= PCF;
        PCPlus4D <= pc_plus4;
        ValidD   <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_valid;

  assign load_valid = run && !FlushD && !stallD;

  // counters stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
      fetch_cnt <= 32'd0;
    end else if (run) begin
      if (stallF && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (FlushD && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
      if (load_valid && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
  assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 1-cycle BRAM model.
// Prints one summary line; FAIL lines on each mismatch.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, FlushD, PcSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr, PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [31:0] stall_cnt, flush_cnt, fetch_cnt;

  int total = 0;
  int bad   = 0;

  int unsigned m_stall, m_flush, m_fetch;
  bit          m_run;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .stallF(stallF), .stallD(stallD), .FlushD(FlushD),
    .PcSrcE(PcSrcE), .PCTargetE(PCTargetE),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmem(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'd3) ^ 32'h5A00_0013;
  endfunction

  always @(posedge clk) imem_rdata <= fmem(imem_addr);

  function automatic logic [31:0] exp_cnt(input int unsigned m);
`ifdef FETCH_PERF_CNT_EN
    return m;
`else
    return (m == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // advance one clock, tracking expected counter values
  task automatic tick();
    if (reset) begin
      m_stall = 0; m_flush = 0; m_fetch = 0; m_run = 0;
    end else begin
      if (m_run) begin
        m_stall += stallF;
        m_flush += FlushD;
        m_fetch += (!FlushD && !stallD);
      end
      m_run = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stallF = 0; stallD = 0; FlushD = 0; PcSrcE = 0;
    PCTargetE = 32'd0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (PCF !== 32'd0 || InstrD !== 32'h13 || PCD !== 32'd0 ||
        PCPlus4D !== 32'd0 || ValidD !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: PCF=%h InstrD=%h PCD=%h P4=%h V=%b",
               PCF, InstrD, PCD, PCPlus4D, ValidD);
    end
    total++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || fetch_cnt !== 0) begin
      bad++;
      $display("FAIL reset_cnts: got %0d %0d %0d want 0 0 0",
               stall_cnt, flush_cnt, fetch_cnt);
    end
    total++;
    if (imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL prime_addr: got %h want 0", imem_addr);
    end
  endtask

  task automatic test_first_fetch();
    tick();
    total++;
    if (PCF !== 32'd0 || ValidD !== 1'b0 || imem_addr !== 32'd4) begin
      bad++;
      $display("FAIL prime_exit: PCF=%h V=%b addr=%h want 0 0 4",
               PCF, ValidD, imem_addr);
    end
    tick();
    total++;
    if (InstrD !== 32'h0050_0093 || PCD !== 32'd0 ||
        PCPlus4D !== 32'd4 || ValidD !== 1'b1) begin
      bad++;
      $display("FAIL first_fetch: I=%h PCD=%h P4=%h V=%b", InstrD,
               PCD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_straight();
    logic [31:0] want;
    for (int k = 3; k <= 5; k++) begin
      tick();
      want = 32'(4 * (k - 1));
      total++;
      if (PCF !== want || PCD !== want - 4 ||
          InstrD !== fmem(want - 4) || ValidD !== 1'b1) begin
        bad++;
        $display("FAIL straight_%0d: PCF=%h PCD=%h I=%h want %h %h %h",
                 k, PCF, PCD, InstrD, want, want - 4, fmem(want - 4));
      end
    end
    total++;
    if (fetch_cnt !== exp_cnt(4)) begin
      bad++;
      $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt,
               exp_cnt(4));
    end
  endtask

  task automatic test_stall();
    logic [31:0] s0;
    do_reset();
    tick(); tick(); tick();
    s0 = stall_cnt;
    stallF = 1; stallD = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (PCF !== 32'd8 || imem_addr !== 32'd8 ||
          InstrD !== fmem(32'd4) || PCD !== 32'd4) begin
        bad++;
        $display("FAIL stall_%0d: PCF=%h addr=%h I=%h PCD=%h", k,
                 PCF, imem_addr, InstrD, PCD);
      end
    end
    total++;
    if (stall_cnt !== exp_cnt(m_stall) ||
        stall_cnt - s0 !== exp_cnt(2)) begin
      bad++;
      $display("FAIL stall_cnt: got %0d want %0d", stall_cnt,
               exp_cnt(m_stall));
    end
    clear_in();
    tick();
    total++;
    if (PCF !== 32'd12 || InstrD !== fmem(32'd8) || PCD !== 32'd8) begin
      bad++;
      $display("FAIL stall_release: PCF=%h I=%h PCD=%h", PCF, InstrD,
               PCD);
    end
  endtask

  task automatic test_redirect();
    PcSrcE = 1; PCTargetE = 32'h0000_0103;
    stallF = 1; FlushD = 1; stallD = 1;
    #1;
    total++;
    if (imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL redir_addr: got %h want 00000100", imem_addr);
    end
    tick();
    total++;
    if (PCF !== 32'h100 || ValidD !== 1'b0 || InstrD !== 32'h13 ||
        PCD !== 32'd0) begin
      bad++;
      $display("FAIL redirect: PCF=%h V=%b I=%h PCD=%h", PCF, ValidD,
               InstrD, PCD);
    end
    clear_in();
    tick();
    total++;
    if (InstrD !== fmem(32'h100) || PCD !== 32'h100 ||
        PCPlus4D !== 32'h104 || ValidD !== 1'b1 || PCF !== 32'h104) begin
      bad++;
      $display("FAIL redir_target: I=%h PCD=%h P4=%h V=%b PCF=%h",
               InstrD, PCD, PCPlus4D, ValidD, PCF);
    end
    total++;
    if (flush_cnt !== exp_cnt(m_flush) ||
        stall_cnt !== exp_cnt(m_stall) ||
        fetch_cnt !== exp_cnt(m_fetch)) begin
      bad++;
      $display("FAIL redir_cnts: got %0d %0d %0d want %0d %0d %0d",
               stall_cnt, flush_cnt, fetch_cnt, exp_cnt(m_stall),
               exp_cnt(m_flush), exp_cnt(m_fetch));
    end
  endtask

  task automatic test_wrap();
    PcSrcE = 1; PCTargetE = 32'hFFFF_FFFF;
    tick();
    clear_in();
    #1;
    total++;
    if (PCF !== 32'hFFFF_FFFC || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL wrap_pc: PCF=%h addr=%h want fffffffc 0", PCF,
               imem_addr);
    end
    tick();
    total++;
    if (PCF !== 32'd0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'd0 ||
        InstrD !== fmem(32'hFFFF_FFFC)) begin
      bad++;
      $display("FAIL wrap_id: PCF=%h PCD=%h P4=%h I=%h", PCF, PCD,
               PCPlus4D, InstrD);
    end
  endtask

  task automatic test_reset_mid();
    tick(); tick();
    stallD = 1; PcSrcE = 1; PCTargetE = 32'h200; FlushD = 1;
    stallF = 1; reset = 1;
    #1;
    total++;
    if (imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL rst_addr: got %h want 0", imem_addr);
    end
    tick();
    total++;
    if (PCF !== 32'd0 || ValidD !== 1'b0 || InstrD !== 32'h13 ||
        stall_cnt !== 0 || flush_cnt !== 0 || fetch_cnt !== 0) begin
      bad++;
      $display("FAIL rst_mid: PCF=%h V=%b I=%h cnt=%0d %0d %0d", PCF,
               ValidD, InstrD, stall_cnt, flush_cnt, fetch_cnt);
    end
    reset = 0;
    clear_in();
    #1;
    total++;
    if (imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL rst_prime: addr=%h want 0", imem_addr);
    end
    tick();
    total++;
    if (PCF !== 32'd0 || ValidD !== 1'b0 || imem_addr !== 32'd4) begin
      bad++;
      $display("FAIL rst_run: PCF=%h V=%b addr=%h", PCF, ValidD,
               imem_addr);
    end
  endtask

  initial begin
    reset = 1;
    clear_in();
    m_stall = 0; m_flush = 0; m_fetch = 0; m_run = 0;
    test_reset();
    test_first_fetch();
    test_straight();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end

endmodule
